// File: rtl/inst_rom_loader.sv
// Instruction ROM for the core fetch port, filled at boot from a byte-stream loader.
// Optional trailer checksum byte enabled by defining INST_ROM_CHECKSUM_EN.
module inst_rom_loader #(
    parameter int unsigned MEM_AW = 10
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              ld_valid_i,
    input  logic [7:0]        ld_data_i,
    output logic              ld_ready_o,
    input  logic              rom_ce_i,
    input  logic [31:0]       rom_addr_i,
    output logic [31:0]       rom_data_o,
    output logic              cpu_hold_o,
    output logic              boot_done_o,
    output logic              load_err_o,
    output logic [MEM_AW:0]   word_cnt_o
);

    localparam int unsigned DEPTH     = 2 ** MEM_AW;
    localparam logic [16:0] DEPTH_EXT = 17'(DEPTH);

    localparam logic [2:0] S_LEN_HI = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;
    localparam logic [2:0] S_CSUM   = 3'd5;

`ifdef INST_ROM_CHECKSUM_EN
    localparam logic [2:0] S_LOADED = S_CSUM;
`else
    localparam logic [2:0] S_LOADED = S_RUN;
`endif

    logic [2:0]        state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [1:0]        lane_q, lane_d;
    logic [23:0]       buf_q, buf_d;
    logic [MEM_AW:0]   word_cnt_q, word_cnt_d;

    logic [31:0]       mem [DEPTH];
    logic              mem_we;
    logic [MEM_AW-1:0] mem_waddr;
    logic [31:0]       mem_wdata;

    logic              accept;
    logic [15:0]       len_new;
    logic [16:0]       len_ext;
    logic [16:0]       wc_next_ext;

    assign accept      = ld_valid_i & ld_ready_o;
    assign len_new     = {len_q[15:8], ld_data_i};
    assign len_ext     = 17'(len_q);
    assign wc_next_ext = 17'(word_cnt_q) + 17'd1;

`ifdef INST_ROM_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            csum_q <= 8'h00;
        end else begin
            csum_q <= csum_d;
        end
    end

    // Only data bytes contribute; the length header is excluded.
    always_comb begin
        csum_d = csum_q;
        if (state_q == S_DATA && accept) begin
            csum_d = csum_q ^ ld_data_i;
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        lane_d     = lane_q;
        buf_d      = buf_q;
        word_cnt_d = word_cnt_q;
        mem_we     = 1'b0;
        mem_waddr  = word_cnt_q[MEM_AW-1:0];
        mem_wdata  = {buf_q, ld_data_i};

        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = {ld_data_i, 8'h00};
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d = len_new;
                    if (len_new == 16'd0) begin
                        state_d = S_LOADED;
                    end else if (17'(len_new) > DEPTH_EXT) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    buf_d  = {buf_q[15:0], ld_data_i};
                    lane_d = lane_q + 2'd1;
                    if (lane_q == 2'd3) begin
                        mem_we     = 1'b1;
                        word_cnt_d = word_cnt_q + 1'b1;
                        // Leave on the edge that writes the final word.
                        if (wc_next_ext == len_ext) begin
                            state_d = S_LOADED;
                        end
                    end
                end
            end
`ifdef INST_ROM_CHECKSUM_EN
            S_CSUM: begin
                if (accept) begin
                    state_d = (ld_data_i == csum_q) ? S_RUN : S_ERR;
                end
            end
`endif
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= S_LEN_HI;
            len_q      <= 16'h0000;
            lane_q     <= 2'd0;
            buf_q      <= 24'h000000;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            lane_q     <= lane_d;
            buf_q      <= buf_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    // Storage has no reset; stale contents are masked by the length check on read.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        ld_ready_o = 1'b0;
        case (state_q)
            S_LEN_HI, S_LEN_LO, S_DATA: ld_ready_o = 1'b1;
`ifdef INST_ROM_CHECKSUM_EN
            S_CSUM:                     ld_ready_o = 1'b1;
`endif
            default:                    ld_ready_o = 1'b0;
        endcase
    end

    assign boot_done_o = (state_q == S_RUN);
    assign load_err_o  = (state_q == S_ERR);
    assign cpu_hold_o  = ~boot_done_o;
    assign word_cnt_o  = word_cnt_q;

    logic [MEM_AW-1:0] rd_idx;
    logic              rd_hi_zero;
    logic              rd_in_len;
    logic              unused_addr_lsb;

    assign rd_idx          = rom_addr_i[MEM_AW+1:2];
    assign rd_hi_zero      = ~|rom_addr_i[31:MEM_AW+2];
    assign rd_in_len       = 17'(rd_idx) < len_ext;
    assign unused_addr_lsb = ^rom_addr_i[1:0];

    always_comb begin
        rom_data_o = 32'h0000_0000;
        if (rom_ce_i && (state_q == S_RUN) && rd_hi_zero && rd_in_len) begin
            rom_data_o = mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Randomized self-checking bench for inst_rom_loader against a stream-level reference model.
module tb_inst_rom_loader;

    localparam int unsigned MEM_AW = 10;
    localparam int unsigned DEPTH  = 2 ** MEM_AW;

    logic              clk;
    logic              rst_n;
    logic              ld_valid;
    logic [7:0]        ld_data;
    logic              ld_ready;
    logic              rom_ce;
    logic [31:0]       rom_addr;
    logic [31:0]       rom_data;
    logic              cpu_hold;
    logic              boot_done;
    logic              load_err;
    logic [MEM_AW:0]   word_cnt;

    inst_rom_loader #(.MEM_AW(MEM_AW)) dut (
        .Clk        (clk),
        .Rst_n      (rst_n),
        .ld_valid_i (ld_valid),
        .ld_data_i  (ld_data),
        .ld_ready_o (ld_ready),
        .rom_ce_i   (rom_ce),
        .rom_addr_i (rom_addr),
        .rom_data_o (rom_data),
        .cpu_hold_o (cpu_hold),
        .boot_done_o(boot_done),
        .load_err_o (load_err),
        .word_cnt_o (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: image length, contents and expected terminal outcome.
    int unsigned exp_n;
    logic [31:0] exp_mem [DEPTH];
    bit          exp_run;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_read(input bit ce, input logic [31:0] addr);
        int unsigned idx;
        idx = addr / 4;
        if (!ce || !exp_run) return 32'h0;
        if (addr >= 4 * DEPTH) return 32'h0;
        if (idx >= exp_n) return 32'h0;
        return exp_mem[idx];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = 8'($urandom);
        rom_ce   = 1'b1;
        rom_addr = 32'h0;
        rst_n    = 1'b0;
        #1;
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_boot_done", boot_done, 0);
        check("rst_load_err", load_err, 0);
        check("rst_rom_data", rom_data, 0);
        check("rst_word_cnt", word_cnt, 0);
        @(negedge clk);
        ld_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        check("rst_ld_ready", ld_ready, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int w;
        @(negedge clk);
        ld_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = b;
        w = 0;
        while (!ld_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!ld_ready) check("ld_ready_wait", ld_ready, 1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    // Sends an image for the current model contents and checks the terminal outputs.
    task automatic run_load(input int max_gap, input bit bad_csum, input int abort_after);
        logic [7:0] q [$];
        logic [7:0] x;
        bit         too_long;
        int unsigned exp_cnt;
        too_long = (exp_n > DEPTH);
        q.push_back(exp_n[15:8]);
        q.push_back(exp_n[7:0]);
        x = 8'h00;
        if (!too_long) begin
            for (int i = 0; i < int'(exp_n); i++) begin
                for (int k = 3; k >= 0; k--) begin
                    q.push_back(exp_mem[i][8*k +: 8]);
                    x = x ^ exp_mem[i][8*k +: 8];
                end
            end
        end
        exp_run = !too_long;
`ifdef INST_ROM_CHECKSUM_EN
        if (!too_long) begin
            q.push_back(bad_csum ? (x ^ 8'h5A) : x);
            exp_run = !bad_csum;
        end
`else
        if (bad_csum) exp_run = !too_long;
`endif
        if (abort_after >= 0) begin
            for (int i = 0; i < abort_after && i < q.size(); i++) send_byte(q[i], max_gap);
            exp_run = 1'b0;
            return;
        end
        for (int i = 0; i < q.size(); i++) begin
            if (i == q.size() - 1) check("done_early", boot_done, 0);
            send_byte(q[i], max_gap);
        end
        exp_cnt = too_long ? 0 : exp_n;
        check("end_boot_done", boot_done, exp_run);
        check("end_cpu_hold", cpu_hold, !exp_run);
        check("end_load_err", load_err, !exp_run);
        check("end_ld_ready", ld_ready, 0);
        check("end_word_cnt", word_cnt, exp_cnt);
    endtask

    task automatic read_chk(input string tag, input bit ce, input logic [31:0] addr);
        @(negedge clk);
        rom_ce   = ce;
        rom_addr = addr;
        #1;
        check(tag, rom_data, exp_read(ce, addr));
    endtask

    task automatic random_reads(input int count);
        logic [31:0] a;
        int r;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(9, 0);
            if (r < 7) a = $urandom_range(exp_n + 2, 0) * 4 + $urandom_range(3, 0);
            else if (r == 7) a = $urandom;
            else a = (32'h1000 << $urandom_range(19, 0)) | $urandom_range(4095, 0);
            read_chk("rand_read", ($urandom_range(7, 0) != 0), a);
        end
    endtask

    task automatic set_t2_image();
        exp_n      = 2;
        exp_mem[0] = 32'h3401_0001;
        exp_mem[1] = 32'h3C02_FFFF;
    endtask

    task automatic t2_reads();
        read_chk("t2_addr0", 1'b1, 32'h0);
        check("t2_addr0_const", rom_data, 32'h3401_0001);
        read_chk("t2_addr4", 1'b1, 32'h4);
        check("t2_addr4_const", rom_data, 32'h3C02_FFFF);
        read_chk("t2_addr6", 1'b1, 32'h6);
        check("t2_addr6_const", rom_data, 32'h3C02_FFFF);
        read_chk("t2_addr8", 1'b1, 32'h8);
        check("t2_addr8_const", rom_data, 32'h0);
        read_chk("t2_ce0", 1'b0, 32'h0);
        check("t2_ce0_const", rom_data, 32'h0);
    endtask

    initial begin
        int unsigned n_pick;
        rst_n    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 8'h00;
        rom_ce   = 1'b0;
        rom_addr = 32'h0;
        exp_n    = 0;
        exp_run  = 1'b0;

        do_reset();
        set_t2_image();
        run_load(0, 1'b0, -1);
        t2_reads();

        // Bytes offered after boot must be ignored.
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        ld_valid = 1'b0;
        check("ignore_word_cnt", word_cnt, 2);
        check("ignore_boot_done", boot_done, 1);
        check("ignore_ld_ready", ld_ready, 0);

        do_reset();
        set_t2_image();
        run_load(3, 1'b0, -1);
        t2_reads();

        do_reset();
        exp_n = 0;
        run_load(2, 1'b0, -1);
        read_chk("n0_addr0", 1'b1, 32'h0);
        random_reads(5);

        do_reset();
        exp_n = 16'h0401;
        run_load(1, 1'b0, -1);
        read_chk("n401_addr0", 1'b1, 32'h0);

        do_reset();
        set_t2_image();
        run_load(1, 1'b0, 5);
        do_reset();
        set_t2_image();
        run_load(0, 1'b0, -1);
        t2_reads();

`ifdef INST_ROM_CHECKSUM_EN
        do_reset();
        set_t2_image();
        run_load(0, 1'b1, -1);
        read_chk("csum_bad_read", 1'b1, 32'h0);
`endif

        for (int it = 0; it < 14; it++) begin
            do_reset();
            n_pick = $urandom_range(15, 0);
            if (n_pick == 15) exp_n = $urandom_range(65535, DEPTH + 1);
            else exp_n = $urandom_range(12, 0);
            for (int i = 0; i < int'(exp_n) && i < int'(DEPTH); i++) exp_mem[i] = $urandom;
            if ($urandom_range(5, 0) == 0) begin
                run_load($urandom_range(3, 0), 1'b0, $urandom_range(9, 1));
                do_reset();
            end
            run_load($urandom_range(3, 0), ($urandom_range(3, 0) == 0), -1);
            random_reads(15);
        end

        do_reset();
        exp_n = DEPTH;
        for (int i = 0; i < int'(DEPTH); i++) exp_mem[i] = $urandom;
        run_load(0, 1'b0, -1);
        read_chk("full_last", 1'b1, 32'(4 * (DEPTH - 1)));
        read_chk("full_first", 1'b1, 32'h0);
        read_chk("full_beyond", 1'b1, 32'(4 * DEPTH));
        random_reads(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
